// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
// State, owner and fetch byte-enable constants plus the grant rule.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_e;

   localparam logic       OWNER_I  = 1'b0;
   localparam logic       OWNER_D  = 1'b1;
   localparam logic [3:0] FETCH_BE = 4'b1111;

   // Data wins unless a fetch is waiting and has been overtaken too often.
   function automatic logic pick_d(
      input logic i_req,
      input logic d_req,
      input logic below_max
   );
      return d_req & (~i_req | below_max);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and memory.
// slave = arbiter view, master = requesters plus memory view.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_done;

   logic          d_req;
   logic          d_we;
   logic [3:0]    d_be;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_done;

   logic          m_req;
   logic          m_we;
   logic [3:0]    m_be;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ack;

   logic          owner;

   modport slave (
      input  i_req, i_addr,
      output i_rdata, i_done,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      output d_rdata, d_done,
      output m_req, m_we, m_be, m_addr, m_wdata,
      input  m_rdata, m_ack,
      output owner
   );

   modport master (
      output i_req, i_addr,
      input  i_rdata, i_done,
      output d_req, d_we, d_be, d_addr, d_wdata,
      input  d_rdata, d_done,
      input  m_req, m_we, m_be, m_addr, m_wdata,
      output m_rdata, m_ack,
      input  owner
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: IF fetch vs MEM load/store.
// Data has priority; a starvation counter forces a fetch through.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input logic            clk,
   input logic            rstn,
   mem_port_arbiter_if.slave bus
);

   localparam int            CW      = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   arb_state_e    state;
   logic [CW-1:0] starve_cnt;
   logic [CW-1:0] starve_inc;
   logic          below_max;
   logic          grant_d;
   logic          grant_i;
   logic [AW-1:0] grant_addr;
   logic [DW-1:0] ack_data;

   assign below_max  = starve_cnt < CNT_MAX;
   assign grant_d    = pick_d(bus.i_req, bus.d_req, below_max);
   assign grant_i    = bus.i_req & ~grant_d;
   assign grant_addr = grant_d ? bus.d_addr : bus.i_addr;
   assign ack_data   = bus.m_rdata;
   assign starve_inc = (starve_cnt == CNT_MAX) ?
                       CNT_MAX : starve_cnt + 1'b1;

   // Arbitration FSM with registered memory-side and completion outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ARB_IDLE;
         starve_cnt  <= '0;
         bus.m_req   <= 1'b0;
         bus.m_we    <= 1'b0;
         bus.m_be    <= '0;
         bus.m_addr  <= '0;
         bus.m_wdata <= '0;
         bus.i_rdata <= '0;
         bus.i_done  <= 1'b0;
         bus.d_rdata <= '0;
         bus.d_done  <= 1'b0;
         bus.owner   <= OWNER_I;
      end else begin
         unique case (state)
            ARB_IDLE: begin
               unique case (1'b1)
                  grant_d: begin
                     bus.owner   <= OWNER_D;
                     bus.m_req   <= 1'b1;
                     bus.m_we    <= bus.d_we;
                     bus.m_be    <= bus.d_be;
                     bus.m_addr  <= grant_addr;
                     bus.m_wdata <= bus.d_wdata;
                     starve_cnt  <= bus.i_req ? starve_inc : '0;
                     state       <= ARB_BUSY;
                  end
                  grant_i: begin
                     bus.owner   <= OWNER_I;
                     bus.m_req   <= 1'b1;
                     bus.m_we    <= 1'b0;
                     bus.m_be    <= FETCH_BE;
                     bus.m_addr  <= grant_addr;
                     bus.m_wdata <= '0;
                     starve_cnt  <= '0;
                     state       <= ARB_BUSY;
                  end
                  default: begin
                     starve_cnt  <= '0;
                  end
               endcase
            end
            ARB_BUSY: begin
               if (bus.m_ack) begin
                  bus.m_req <= 1'b0;
                  state     <= ARB_DONE;
                  if (bus.owner == OWNER_I) begin
                     bus.i_rdata <= ack_data;
                     bus.i_done  <= 1'b1;
                  end else begin
                     bus.d_done <= 1'b1;
                     if (!bus.m_we) begin
                        bus.d_rdata <= ack_data;
                     end
                  end
               end
            end
            ARB_DONE: begin
               bus.i_done <= 1'b0;
               bus.d_done <= 1'b0;
               state      <= ARB_IDLE;
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule
